// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// Module      : keypad_pkg
// Description : Shared types, column strobes and key map for keypad_scanner.
// Revision    : 1.0 - initial release
// ============================================================================
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2
  } state_e;

  typedef struct packed {
    logic       hit;
    logic [1:0] idx;
  } row_hit_t;

  localparam logic [3:0] C_COL0 = 4'b1110;
  localparam logic [3:0] C_COL1 = 4'b1101;
  localparam logic [3:0] C_COL2 = 4'b1011;
  localparam logic [3:0] C_COL3 = 4'b0111;

  function automatic logic [3:0] col_strobe(input logic [1:0] c);
    logic [3:0] s;
    case (c)
      2'd0:    s = C_COL0;
      2'd1:    s = C_COL1;
      2'd2:    s = C_COL2;
      default: s = C_COL3;
    endcase
    return s;
  endfunction

  // Only a single low row is a usable hit; multiple lows are treated as ghosting.
  function automatic row_hit_t decode_rows(input logic [3:0] rows);
    row_hit_t res;
    res = '0;
    case (rows)
      4'b1110: begin res.hit = 1'b1; res.idx = 2'd0; end
      4'b1101: begin res.hit = 1'b1; res.idx = 2'd1; end
      4'b1011: begin res.hit = 1'b1; res.idx = 2'd2; end
      4'b0111: begin res.hit = 1'b1; res.idx = 2'd3; end
      default: res = '0;
    endcase
    return res;
  endfunction

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    case ({r, c})
      4'b00_00: k = 4'h1;
      4'b00_01: k = 4'h2;
      4'b00_10: k = 4'h3;
      4'b00_11: k = 4'hA;
      4'b01_00: k = 4'h4;
      4'b01_01: k = 4'h5;
      4'b01_10: k = 4'h6;
      4'b01_11: k = 4'hB;
      4'b10_00: k = 4'h7;
      4'b10_01: k = 4'h8;
      4'b10_10: k = 4'h9;
      4'b10_11: k = 4'hC;
      4'b11_00: k = 4'h0;
      4'b11_01: k = 4'hF;
      4'b11_10: k = 4'hE;
      default:  k = 4'hD;
    endcase
    return k;
  endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_sync.sv
`default_nettype none
// ============================================================================
// Module      : keypad_sync
// Description : 4-bit two-flop synchronizer, resets to all-high (no key).
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_sync (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] d_in,
  output logic [3:0] d_out
);

  logic [3:0] meta_q;
  logic [3:0] sync_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta_q <= 4'b1111;
      sync_q <= 4'b1111;
    end else begin
      meta_q <= d_in;
      sync_q <= meta_q;
    end
  end

  assign d_out = sync_q;

endmodule
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module      : keypad_scanner
// Description : 4x4 matrix keypad scanner with debounce; one hex code per
//               press. Define KEYPAD_REPEAT_EN for auto-repeat while held.
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV_BITS  = 17,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_TICKS   = 64
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam logic [SCAN_DIV_BITS-1:0] C_DIV_ONE = {{(SCAN_DIV_BITS-1){1'b0}}, 1'b1};
  localparam logic [3:0]               C_DEB_LIMIT = 4'(DEBOUNCE_SCANS);

  if (SCAN_DIV_BITS < 3) begin : g_bad_div
    $error("SCAN_DIV_BITS must be at least 3");
  end
  if (DEBOUNCE_SCANS < 2 || DEBOUNCE_SCANS > 15) begin : g_bad_deb
    $error("DEBOUNCE_SCANS must be within 2..15");
  end
  if (REPEAT_TICKS < 1) begin : g_bad_rep
    $error("REPEAT_TICKS must be positive");
  end

  logic [3:0]               row_sync;
  row_hit_t                 row_hit;
  logic [SCAN_DIV_BITS-1:0] div_q, div_d;
  state_e                   state_q, state_d;
  logic [1:0]               col_idx_q, col_idx_d;
  logic [1:0]               row_lat_q, row_lat_d;
  logic [3:0]               deb_cnt_q, deb_cnt_d;
  logic [3:0]               rel_cnt_q, rel_cnt_d;
  logic [3:0]               key_code_q, key_code_d;
  logic                     key_valid_q, key_valid_d;
  logic                     key_held_q, key_held_d;
  logic                     tick;
  logic                     deb_match;
  logic                     deb_done;
  logic                     all_high;
  logic                     rel_done;
  logic                     rep_fire;

  keypad_sync u_sync (
    .clock (clock),
    .reset (reset),
    .d_in  (row),
    .d_out (row_sync)
  );

  assign row_hit   = decode_rows(row_sync);
  assign div_d     = div_q + C_DIV_ONE;
  // Tick is the last count before the divider wraps back to zero.
  assign tick      = &div_q;
  assign deb_match = row_hit.hit && (row_hit.idx == row_lat_q);
  assign deb_done  = tick && (state_q == ST_DEBOUNCE) && deb_match
                     && ((deb_cnt_q + 4'd1) == C_DEB_LIMIT);
  assign all_high  = (row_sync == 4'b1111);
  assign rel_done  = tick && (state_q == ST_HELD) && all_high
                     && ((rel_cnt_q + 4'd1) == C_DEB_LIMIT);

`ifdef KEYPAD_REPEAT_EN
  localparam int               C_REP_W     = $clog2(REPEAT_TICKS + 1);
  localparam logic [C_REP_W-1:0] C_REP_LIMIT = C_REP_W'(REPEAT_TICKS);
  localparam logic [C_REP_W-1:0] C_REP_ONE   = {{(C_REP_W-1){1'b0}}, 1'b1};

  logic [C_REP_W-1:0] rep_cnt_q, rep_cnt_d;

  assign rep_fire = tick && (state_q == ST_HELD) && !rel_done
                    && ((rep_cnt_q + C_REP_ONE) == C_REP_LIMIT);

  // Held at zero outside HELD so entry always restarts the interval.
  always_comb begin
    rep_cnt_d = rep_cnt_q;
    if (state_q != ST_HELD) begin
      rep_cnt_d = '0;
    end else if (tick) begin
      rep_cnt_d = rep_fire ? '0 : (rep_cnt_q + C_REP_ONE);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rep_cnt_q <= '0;
    end else begin
      rep_cnt_q <= rep_cnt_d;
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      div_q       <= '0;
      state_q     <= ST_SCAN;
      col_idx_q   <= 2'd0;
      row_lat_q   <= 2'd0;
      deb_cnt_q   <= 4'd0;
      rel_cnt_q   <= 4'd0;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      div_q       <= div_d;
      state_q     <= state_d;
      col_idx_q   <= col_idx_d;
      row_lat_q   <= row_lat_d;
      deb_cnt_q   <= deb_cnt_d;
      rel_cnt_q   <= rel_cnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    col_idx_d = col_idx_q;
    row_lat_d = row_lat_q;
    deb_cnt_d = deb_cnt_q;
    rel_cnt_d = rel_cnt_q;
    if (tick) begin
      case (state_q)
        ST_SCAN: begin
          if (row_hit.hit) begin
            row_lat_d = row_hit.idx;
            deb_cnt_d = 4'd0;
            state_d   = ST_DEBOUNCE;
          end else begin
            col_idx_d = col_idx_q + 2'd1;
          end
        end
        ST_DEBOUNCE: begin
          if (deb_done) begin
            rel_cnt_d = 4'd0;
            state_d   = ST_HELD;
          end else if (deb_match) begin
            deb_cnt_d = deb_cnt_q + 4'd1;
          end else begin
            col_idx_d = col_idx_q + 2'd1;
            state_d   = ST_SCAN;
          end
        end
        ST_HELD: begin
          if (rel_done) begin
            rel_cnt_d = 4'd0;
            col_idx_d = col_idx_q + 2'd1;
            state_d   = ST_SCAN;
          end else if (all_high) begin
            rel_cnt_d = rel_cnt_q + 4'd1;
          end else begin
            rel_cnt_d = 4'd0;
          end
        end
        default: state_d = ST_SCAN;
      endcase
    end
  end

  always_comb begin
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    if (deb_done) begin
      key_code_d  = key_map(row_lat_q, col_idx_q);
      key_valid_d = 1'b1;
      key_held_d  = 1'b1;
    end
    if (rel_done) begin
      key_held_d = 1'b0;
    end
    if (rep_fire) begin
      key_valid_d = 1'b1;
    end
  end

  assign col       = col_strobe(col_idx_q);
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule
`default_nettype wire

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 matrix keypad (Pmod KYPD style) on the input side of the board, debounces presses and reports one hex key code per press. It is the input counterpart of the seven-segment display path. It drives column strobes the way the display scanner drives anodes, reads the row returns, and produces a 4-bit code that feeds the seven_seg_decoder digit inputs directly. It runs on the system clock and uses an internal scan tick, so no external clock_div instance is needed.

## Interface
- SCAN_DIV_BITS, 17: width of the free-running scan-tick counter. One tick per 2^SCAN_DIV_BITS clocks. Must be ≥ 3.
- DEBOUNCE_SCANS, 4: number of consecutive equal tick samples needed to accept a press or a release. Range 2–15.
- REPEAT_TICKS, 64: auto-repeat interval in ticks. Used only with KEYPAD_REPEAT_EN.

Ports:
- clock  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- row  in  4  keypad row returns, active-low with external pull-ups; asynchronous to clock.
- col  out  4  column strobes, active-low one-hot.
- key_code  out  4  hex code of the accepted key; holds its value until the next accepted key.
- key_valid  out  1  one-cycle pulse when key_code updates.
- key_held  out  1  high while an accepted key stays pressed.

## Operation
- Row inputs pass through a 2-flop synchronizer before any use.
- Tick: asserted for one cycle when the SCAN_DIV_BITS counter wraps to 0. All state-machine decisions happen on tick cycles only.
- Row pattern decode: exactly one synchronized row low gives a valid hit with row index r. All rows high, or two or more rows low, counts as "no key".
- Key map, row r / column c to key_code:
  - r0: 1, 2, 3, A
  - r1: 4, 5, 6, B
  - r2: 7, 8, 9, C
  - r3: 0, F, E, D
- State machine:
  - SCAN: on each tick, if there is no valid hit, advance the column 0→1→2→3→0. On a valid hit, latch (r, c), clear the debounce count and go to DEBOUNCE; the column freezes.
  - DEBOUNCE: on each tick, if the same single row is still low, increment the count. When the count reaches DEBOUNCE_SCANS, load key_code, pulse key_valid, set key_held and go to HELD. On any other pattern, return to SCAN and advance to the next column.
  - HELD: the column stays frozen. Each tick with all rows high increments the release count; any tick with rows low clears it. When the release count reaches DEBOUNCE_SCANS, clear key_held and go to SCAN, advancing the column.
- Any change of key while in HELD (for example a different row going low) is ignored until release completes.

## Timing
- Reset values: col=4'b1110, key_code=4'h0, key_valid=0, key_held=0, state=SCAN, all counters 0.
- Reset takes effect on the clock edge where reset is sampled high, including mid-DEBOUNCE or mid-HELD. No key_valid is emitted for a press that is interrupted by reset.
- col changes only in the cycle after a tick. The 2^SCAN_DIV_BITS ≥ 8 cycle spacing covers the 2-cycle synchronizer latency plus pad settling.
- key_valid asserts in the cycle after the tick that completes debounce. key_code and key_held update in that same cycle.
- Press-to-key_valid latency: DEBOUNCE_SCANS+1 ticks after the first tick that sees the press, worst case plus 3 column ticks to reach the column.
- key_held falls in the cycle after the tick that completes release debounce.

## Configuration
- KEYPAD_REPEAT_EN defined: a tick counter runs in HELD. Every REPEAT_TICKS ticks it re-pulses key_valid with an unchanged key_code, then restarts. The counter clears on entry to HELD, so the first repeat comes REPEAT_TICKS ticks after the initial pulse.
- KEYPAD_REPEAT_EN undefined: exactly one key_valid per press. The repeat counter is not instantiated.

## Structure
- keypad_pkg holds the state enum (SCAN, DEBOUNCE, HELD), the key-map constant/function (r, c) → code, and the one-hot active-low column constants.
- One sub-module, keypad_sync: a 4-bit 2-flop synchronizer with synchronous reset to 4'b1111.
- The counters and the state machine live in keypad_scanner.

## Test plan
Bench settings: SCAN_DIV_BITS=3, DEBOUNCE_SCANS=4. The keypad model sets row[r]=0 iff key (r,c) is pressed and col[c]=0.
- Reset: assert reset for 2 cycles → col=1110, key_code=0, key_valid=0, key_held=0. With no press, col cycles 1110→1101→1011→0111→1110 every 8 clocks.
- Press: press (1,2) steadily → exactly one key_valid pulse with key_code=4'h6 and key_held=1. Release → key_held=0 after 4 all-high ticks, then scanning resumes.
- Bounce: toggle (2,0) every tick for 3 ticks, then release → no key_valid, key_code unchanged.
- Ghost rejection: press (0,3) and (3,3) together → no key_valid. Release (0,3) while keeping (3,3) → key_valid with key_code=4'hD.
- Reset mid-press: assert reset during DEBOUNCE, and separately during HELD → all outputs return to reset values on the next edge, with no pulse.
- Repeat: with KEYPAD_REPEAT_EN and REPEAT_TICKS=8, hold (3,0) for 20 ticks past acceptance → 3 key_valid pulses, all with key_code=4'h0. Without the macro → 1 pulse.
